reg_file: RTL and testbench

General-purpose register file of the single-cycle/pipelined MIPS datapath: it supplies the two 32-bit operands consumed by the ALU (`src1_i`, `src2_i`) and accepts the write-back of ALU results. It holds 32 × 32-bit registers with `$0` hard-wired to zero, a write-to-read bypass, and a pending-write scoreboard so issue logic can detect read-after-write hazards against in-flight producers. A registered debug read port exposes register contents to the testbench.

---
 rtl/mips_pkg.sv | 10 +
 rtl/reg_scoreboard.sv | 48 ++++
 rtl/reg_file.sv | 80 ++++++++
 tb/tb_reg_file.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, reset constants and register-index type for the MIPS datapath
package mips_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;
    localparam int SP_IDX   = 29;
    localparam int SP_INIT  = 128;

    typedef logic [ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write bit per register with busy lookup for two query ports
module reg_scoreboard
    import mips_pkg::*;
#(
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    input  logic [ADDR_W-1:0] qa_addr_i,
    input  logic [ADDR_W-1:0] qb_addr_i,
    output logic              qa_busy_o,
    output logic              qb_busy_o
);
    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;
    logic            wr_live;

    assign wr_live = we_i && (rd_addr_i != ADDR_W'(REG_ZERO));

    // Clear before set so a same-cycle issue to the written index stays pending.
    always_comb begin
        pending_nxt = pending;
        if (wr_live) begin
            pending_nxt[rd_addr_i] = 1'b0;
        end
        if (issue_i && (issue_addr_i != ADDR_W'(REG_ZERO))) begin
            pending_nxt[issue_addr_i] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign qa_busy_o = !rst_i && pending[qa_addr_i] && !(we_i && (rd_addr_i == qa_addr_i));
    assign qb_busy_o = !rst_i && pending[qb_addr_i] && !(we_i && (rd_addr_i == qb_addr_i));
endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file with $0 tied to zero, write bypass, scoreboard and debug port
module reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W  = mips_pkg::DATA_W,
    parameter int ADDR_W  = mips_pkg::ADDR_W,
    parameter int SP_IDX  = mips_pkg::SP_IDX,
    parameter int SP_INIT = mips_pkg::SP_INIT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic              rs_busy_o,
    output logic              rt_busy_o,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic              bypass_ok;

    assign bypass_ok = !rst_i && we_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
            end
            dbg_data_o <= '0;
        end else begin
            if (we_i && (rd_addr_i != ADDR_W'(REG_ZERO))) begin
                regs[rd_addr_i] <= rd_data_i;
            end
            // Sampled from the array before this edge's write lands: old value on collision.
            dbg_data_o <= regs[dbg_addr_i];
        end
    end

    always_comb begin
        rs_data_o = regs[rs_addr_i];
        if (rs_addr_i == ADDR_W'(REG_ZERO)) begin
            rs_data_o = '0;
        end else if (bypass_ok && (rd_addr_i == rs_addr_i)) begin
            rs_data_o = rd_data_i;
        end
    end

    always_comb begin
        rt_data_o = regs[rt_addr_i];
        if (rt_addr_i == ADDR_W'(REG_ZERO)) begin
            rt_data_o = '0;
        end else if (bypass_ok && (rd_addr_i == rt_addr_i)) begin
            rt_data_o = rd_data_i;
        end
    end

    reg_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_scoreboard (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .we_i        (we_i),
        .rd_addr_i   (rd_addr_i),
        .issue_i     (issue_i),
        .issue_addr_i(issue_addr_i),
        .qa_addr_i   (rs_addr_i),
        .qb_addr_i   (rt_addr_i),
        .qa_busy_o   (rs_busy_o),
        .qb_busy_o   (rt_busy_o)
    );
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed and random checks of reg_file against an array-level model
module tb_reg_file;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  rs_addr_i;
    logic [4:0]  rt_addr_i;
    logic [31:0] rs_data_o;
    logic [31:0] rt_data_o;
    logic        rs_busy_o;
    logic        rt_busy_o;
    logic        issue_i;
    logic [4:0]  issue_addr_i;
    logic        we_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_data_o;

    reg_file dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rs_addr_i   (rs_addr_i),
        .rt_addr_i   (rt_addr_i),
        .rs_data_o   (rs_data_o),
        .rt_data_o   (rt_data_o),
        .rs_busy_o   (rs_busy_o),
        .rt_busy_o   (rt_busy_o),
        .issue_i     (issue_i),
        .issue_addr_i(issue_addr_i),
        .we_i        (we_i),
        .rd_addr_i   (rd_addr_i),
        .rd_data_i   (rd_data_i),
        .dbg_addr_i  (dbg_addr_i),
        .dbg_data_o  (dbg_data_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    logic [31:0] m_dbg;

    logic [31:0] obs_rs, obs_rt;
    logic        obs_rsb, obs_rtb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = (i == 29) ? 32'd128 : 32'd0;
            m_pend[i] = 1'b0;
        end
        m_dbg = 32'd0;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (!rst_i && we_i && rd_addr_i == a) return rd_data_i;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        return !rst_i && m_pend[a] && !(we_i && rd_addr_i == a);
    endfunction

    task automatic step(input logic r, input logic w, input logic [4:0] rd, input logic [31:0] wd,
                        input logic is, input logic [4:0] ia,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        rst_i = r; we_i = w; rd_addr_i = rd; rd_data_i = wd;
        issue_i = is; issue_addr_i = ia;
        rs_addr_i = a; rt_addr_i = b; dbg_addr_i = d;
        @(negedge clk_i);
        obs_rs = rs_data_o; obs_rt = rt_data_o; obs_rsb = rs_busy_o; obs_rtb = rt_busy_o;
        check("rs_data", obs_rs, exp_read(a));
        check("rt_data", obs_rt, exp_read(b));
        check("rs_busy", {31'd0, obs_rsb}, {31'd0, exp_busy(a)});
        check("rt_busy", {31'd0, obs_rtb}, {31'd0, exp_busy(b)});
        @(posedge clk_i);
        if (r) begin
            model_reset();
        end else begin
            m_dbg = m_regs[d];
            if (w && rd != 5'd0) begin
                m_regs[rd] = wd;
                m_pend[rd] = 1'b0;
            end
            if (is && ia != 5'd0) m_pend[ia] = 1'b1;
        end
        #1;
        check("dbg_data", dbg_data_o, m_dbg);
    endtask

    initial begin
        rst_i = 1'b1; we_i = 1'b0; rd_addr_i = '0; rd_data_i = '0;
        issue_i = 1'b0; issue_addr_i = '0; rs_addr_i = '0; rt_addr_i = '0; dbg_addr_i = '0;
        @(posedge clk_i);
        model_reset();
        #1;
        check("reset_dbg", dbg_data_o, 32'd0);

        step(0, 0, 0, 0, 0, 0, 29, 5, 0);
        check("reset_sp", obs_rs, 32'd128);
        check("reset_r5", obs_rt, 32'd0);
        check("reset_busy", {30'd0, obs_rsb, obs_rtb}, 32'd0);

        step(0, 1, 8, 32'hDEADBEEF, 0, 0, 8, 0, 8);
        check("bypass_r8", obs_rs, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 8, 0, 8);
        check("array_r8", obs_rs, 32'hDEADBEEF);
        check("dbg_r8", dbg_data_o, 32'hDEADBEEF);

        step(0, 1, 0, 32'h12345678, 0, 0, 0, 0, 0);
        check("r0_rs", obs_rs, 32'd0);
        check("r0_rt", obs_rt, 32'd0);
        check("r0_dbg", dbg_data_o, 32'd0);

        step(0, 0, 0, 0, 1, 10, 0, 10, 0);
        step(0, 0, 0, 0, 0, 0, 0, 10, 0);
        check("r10_busy", {31'd0, obs_rtb}, 32'd1);
        step(0, 1, 10, 32'd7, 0, 0, 0, 10, 0);
        check("r10_wb_busy", {31'd0, obs_rtb}, 32'd0);
        check("r10_wb_data", obs_rt, 32'd7);
        step(0, 0, 0, 0, 0, 0, 0, 10, 0);
        check("r10_after", {31'd0, obs_rtb}, 32'd0);

        step(0, 1, 3, 32'd9, 1, 3, 3, 0, 0);
        step(0, 0, 0, 0, 0, 0, 3, 0, 0);
        check("r3_data", obs_rs, 32'd9);
        check("r3_busy", {31'd0, obs_rsb}, 32'd1);

        step(0, 1, 4, 32'd55, 1, 4, 4, 0, 0);
        step(1, 1, 4, 32'd99, 1, 5, 4, 29, 4);
        check("rst_nobypass", obs_rs, 32'd55);
        step(0, 0, 0, 0, 0, 0, 4, 29, 0);
        check("rst_r4", obs_rs, 32'd0);
        check("rst_sp", obs_rt, 32'd128);
        check("rst_busy", {30'd0, obs_rsb, obs_rtb}, 32'd0);

        for (int n = 0; n < 400; n++) begin
            logic [4:0] ra, rb, rw, ri, rdbg;
            ra   = 5'($urandom_range(0, 7));
            rb   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rw   = 5'($urandom_range(0, 7));
            ri   = 5'($urandom_range(0, 7));
            rdbg = 5'($urandom_range(0, 7));
            step(($urandom_range(0, 49) == 0), 1'($urandom), rw, $urandom,
                 1'($urandom), ri, ra, rb, rdbg);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
